// File: rtl/mem_responder.sv
// Responder end of the cache-to-memory request/response interface: accepts line
// commands, collects masked write beats, and returns read beats after a fixed latency.
module mem_responder #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int DATA_CYCLES   = 4,
    parameter int DEPTH_LOG2    = 12,
    parameter int READ_LATENCY  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_val,
    output logic                       mem_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic                       mem_req_rw,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_val,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int BEAT_BITS = $clog2(DATA_CYCLES);
    localparam int LINE_BITS = DEPTH_LOG2 - BEAT_BITS;
    localparam int MASK_BITS = MEM_DATA_BITS / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_RWAIT = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    localparam logic [BEAT_BITS-1:0] BEAT_ZERO = BEAT_BITS'(0);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(DATA_CYCLES - 1);
    localparam logic [3:0]           LAT_INIT  = 4'(READ_LATENCY - 1);

    logic [1:0]             state_r, state_s;
    logic [BEAT_BITS-1:0]   beat_r, beat_s;
    logic [3:0]             lat_r, lat_s;
    logic [LINE_BITS-1:0]   line_r, line_s;
    logic                   cmd_fire_s;
    logic                   data_fire_s;
    logic                   wr_en_s;
    logic                   rd_en_s;
    logic [DEPTH_LOG2-1:0]  wr_idx_s;
    logic [DEPTH_LOG2-1:0]  rd_idx_s;
    logic [MEM_DATA_BITS-1:0] resp_data_r;
    logic [MEM_DATA_BITS-1:0] mem_r [DEPTH];
    logic                   addr_unused_s;

    // Upper bits alias onto the array and the low bits select a beat the burst already covers.
    assign addr_unused_s = ^{mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2], mem_req_addr[BEAT_BITS-1:0]};

    assign mem_req_rdy        = (state_r == ST_IDLE) && !reset;
    assign mem_req_data_ready = (state_r == ST_WDATA);
    assign mem_resp_val       = (state_r == ST_RDATA);
    assign mem_resp_data      = resp_data_r;

    assign cmd_fire_s  = mem_req_val && mem_req_rdy;
    assign data_fire_s = mem_req_data_valid && mem_req_data_ready;
    assign wr_idx_s    = {line_r, beat_r};

    // Next-state logic; reads are issued one edge ahead so each beat appears from a register.
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        lat_s    = lat_r;
        line_s   = line_r;
        wr_en_s  = 1'b0;
        rd_en_s  = 1'b0;
        rd_idx_s = {line_r, beat_r + BEAT_ONE};
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    line_s = mem_req_addr[DEPTH_LOG2-1:BEAT_BITS];
                    beat_s = BEAT_ZERO;
                    if (mem_req_rw) begin
                        state_s = ST_WDATA;
                    end else if (READ_LATENCY == 1) begin
                        rd_en_s  = 1'b1;
                        rd_idx_s = {mem_req_addr[DEPTH_LOG2-1:BEAT_BITS], BEAT_ZERO};
                        state_s  = ST_RDATA;
                    end else begin
                        lat_s   = LAT_INIT;
                        state_s = ST_RWAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (data_fire_s) begin
                    wr_en_s = 1'b1;
                    if (beat_r == BEAT_LAST) begin
                        beat_s  = BEAT_ZERO;
                        state_s = ST_IDLE;
                    end else begin
                        beat_s = beat_r + BEAT_ONE;
                    end
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_RWAIT: begin
                if (lat_r <= 4'd1) begin
                    rd_en_s  = 1'b1;
                    rd_idx_s = {line_r, BEAT_ZERO};
                    beat_s   = BEAT_ZERO;
                    lat_s    = 4'd0;
                    state_s  = ST_RDATA;
                end else begin
                    lat_s = lat_r - 4'd1;
                end
            end
            ST_RDATA: begin
                if (beat_r == BEAT_LAST) begin
                    beat_s  = BEAT_ZERO;
                    state_s = ST_IDLE;
                end else begin
                    beat_s  = beat_r + BEAT_ONE;
                    rd_en_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = BEAT_ZERO;
                lat_s   = 4'd0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            beat_r  <= BEAT_ZERO;
            lat_r   <= 4'd0;
            line_r  <= LINE_BITS'(0);
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            lat_r   <= lat_s;
            line_r  <= line_s;
        end
    end

    // Registered read port; holds the last beat whenever no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data_r <= MEM_DATA_BITS'(0);
        end else if (rd_en_s) begin
            resp_data_r <= mem_r[rd_idx_s];
        end else begin
            resp_data_r <= resp_data_r;
        end
    end

    // Byte-masked write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem_r[wr_idx_s][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (latency 3 and latency 1) share one request stream.
module tb_mem_responder;

    localparam int W  = 128;
    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_val = 1'b0;
    logic          mem_req_rw = 1'b0;
    logic [AW-1:0] mem_req_addr = '0;
    logic          mem_req_data_valid = 1'b0;
    logic [W-1:0]  mem_req_data_bits = '0;
    logic [15:0]   mem_req_data_mask = '0;

    logic          rdy0, drdy0, rval0, rdy1, drdy1, rval1;
    logic [W-1:0]  rdata0, rdata1;

    always #5 clk = ~clk;

    mem_responder #(.READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .mem_req_val(mem_req_val), .mem_req_rdy(rdy0),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(drdy0),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_val(rval0), .mem_resp_data(rdata0)
    );

    mem_responder #(.READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .mem_req_val(mem_req_val), .mem_req_rdy(rdy1),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(drdy1),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_val(rval1), .mem_resp_data(rdata1)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    exp_t         q0[$];
    exp_t         q1[$];
    int           fe0[$];
    int           fe1[$];
    logic [W-1:0] model [int];
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    logic [W-1:0] wb [4];
    logic [15:0]  wm [4];
    exp_t         e_tmp;
    logic         exp0, exp1;
    int           rbase;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input int idx);
        if (model.exists(idx)) return model[idx];
        return {W{1'bx}};
    endfunction

    // Response checking and expectation capture, sampled on the falling edge.
    always @(negedge clk) begin
        exp0 = (q0.size() > 0) && (q0[0].due == cyc);
        check_eq("resp_val_l3", W'(rval0), W'(exp0));
        if (exp0) begin
            e_tmp = q0.pop_front();
            check_eq("resp_data_l3", rdata0, e_tmp.data);
            last0 = e_tmp.data;
        end else if (!rval0) begin
            check_eq("resp_hold_l3", rdata0, last0);
        end
        exp1 = (q1.size() > 0) && (q1[0].due == cyc);
        check_eq("resp_val_l1", W'(rval1), W'(exp1));
        if (exp1) begin
            e_tmp = q1.pop_front();
            check_eq("resp_data_l1", rdata1, e_tmp.data);
            last1 = e_tmp.data;
        end else if (!rval1) begin
            check_eq("resp_hold_l1", rdata1, last1);
        end
        rbase = int'(mem_req_addr[11:0]) & 32'hFFC;
        if (mem_req_val && !mem_req_rw && rdy0) begin
            fe0.push_back(cyc + 1);
            for (int k = 0; k < 4; k++) begin
                e_tmp.data = model_rd(rbase + k);
                e_tmp.due  = cyc + 1 + 3 - 1 + k;
                q0.push_back(e_tmp);
            end
        end
        if (mem_req_val && !mem_req_rw && rdy1) begin
            fe1.push_back(cyc + 1);
            for (int k = 0; k < 4; k++) begin
                e_tmp.data = model_rd(rbase + k);
                e_tmp.due  = cyc + 1 + k;
                q1.push_back(e_tmp);
            end
        end
    end

    // Holds a command valid until both responders have taken it; leaves valid asserted.
    task automatic send_cmd(input logic [AW-1:0] a, input logic rw);
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        int n = 0;
        mem_req_addr = a;
        mem_req_rw   = rw;
        mem_req_val  = 1'b1;
        while (!(d0 && d1) && n < 100) begin
            @(negedge clk);
            if (rdy0) d0 = 1'b1;
            if (rdy1) d1 = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("cmd_accept", W'(d0 && d1), W'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        mem_req_val = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rdy0 && rdy1) && n < 100);
        check_eq("idle_reached", W'(rdy0 && rdy1), W'(1));
        @(posedge clk);
        #1;
    endtask

    // Writes wb/wm to a line; pat gives per-slot data valid, hold keeps a read pending meanwhile.
    task automatic write_line(input logic [AW-1:0] a, input logic [15:0] pat, input bit hold);
        int k = 0;
        int s = 0;
        int base = int'(a[11:0]) & 32'hFFC;
        send_cmd(a, 1'b1);
        if (hold) begin
            mem_req_rw   = 1'b0;
            mem_req_addr = 28'h300;
        end else begin
            mem_req_val = 1'b0;
        end
        while (k < 4 && s < 50) begin
            mem_req_data_valid = (s < 16) ? pat[s] : 1'b1;
            mem_req_data_bits  = wb[k];
            mem_req_data_mask  = wm[k];
            @(negedge clk);
            check_eq("rdy_in_wdata", W'({rdy0, rdy1}), W'(0));
            check_eq("data_ready_wdata", W'({drdy0, drdy1}), W'(3));
            if (mem_req_data_valid && drdy0) begin
                if (!model.exists(base + k)) model[base + k] = '0;
                for (int j = 0; j < 16; j++)
                    if (wm[k][j]) model[base + k][8*j +: 8] = wb[k][8*j +: 8];
                k++;
            end
            @(posedge clk);
            #1;
            s++;
        end
        mem_req_data_valid = 1'b0;
        mem_req_val        = 1'b0;
        check_eq("beats_written", W'(k), W'(4));
        @(negedge clk);
        check_eq("rdy_after_write", W'({rdy0, rdy1}), W'(3));
        check_eq("data_ready_idle", W'({drdy0, drdy1}), W'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [15:0] m);
        wb[0] = {16{b0}}; wb[1] = {16{b1}}; wb[2] = {16{b2}}; wb[3] = {16{b3}};
        for (int i = 0; i < 4; i++) wm[i] = m;
    endtask

    task automatic read_line(input logic [AW-1:0] a);
        send_cmd(a, 1'b0);
        wait_idle();
    endtask

    initial begin
        @(negedge clk);
        check_eq("reset_outputs_l3", W'({rdy0, drdy0, rval0}), W'(0));
        check_eq("reset_outputs_l1", W'({rdy1, drdy1, rval1}), W'(0));
        check_eq("reset_resp_data", rdata0 | rdata1, W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_reset", W'({rdy0, rdy1}), W'(3));
        @(posedge clk);
        #1;

        // Full line write then read with an unaligned line address
        fill(8'h11, 8'h22, 8'h33, 8'h44, 16'hFFFF);
        write_line(28'h40, 16'hFFFF, 1'b0);
        read_line(28'h42);

        // Byte mask: only the low 4 bytes of beat 0 change
        fill(8'hAA, 8'hAA, 8'hAA, 8'hAA, 16'hFFFF);
        write_line(28'h80, 16'hFFFF, 1'b0);
        fill(8'h55, 8'h66, 8'h77, 8'h88, 16'h0000);
        wm[0] = 16'h000F;
        write_line(28'h80, 16'hFFFF, 1'b0);
        read_line(28'h80);

        // Throttled write data with a read command held during WDATA
        fill(8'hC1, 8'hC2, 8'hC3, 8'hC4, 16'hFFFF);
        write_line(28'hC0, 16'h0059, 1'b1);
        read_line(28'hC0);

        // Back-to-back reads with valid held high
        fill(8'h01, 8'h02, 8'h03, 8'h04, 16'hFFFF);
        write_line(28'h0, 16'hFFFF, 1'b0);
        fill(8'h05, 8'h06, 8'h07, 8'h08, 16'hFFFF);
        write_line(28'h4, 16'hFFFF, 1'b0);
        fe0.delete();
        fe1.delete();
        send_cmd(28'h0, 1'b0);
        send_cmd(28'h4, 1'b0);
        wait_idle();
        check_eq("b2b_fire_count", W'(fe0.size() + fe1.size()), W'(4));
        if (fe0.size() == 2 && fe1.size() == 2) begin
            check_eq("b2b_gap_l1", W'(fe1[1] - fe1[0]), W'(5));
            check_eq("b2b_gap_l3", W'(fe0[1] - fe0[0]), W'(7));
        end

        // Aliasing: line 0x1000 lands on line 0x0000
        fill(8'hE1, 8'hE2, 8'hE3, 8'hE4, 16'hFFFF);
        write_line(28'h1000, 16'hFFFF, 1'b0);
        read_line(28'h0);

        // Reset during beat 1 of a latency-3 read
        send_cmd(28'h40, 1'b0);
        mem_req_val = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_val_drop", W'({rval0, rval1}), W'(0));
        check_eq("async_rdy_drop", W'({rdy0, rdy1}), W'(0));
        check_eq("async_data_clear", rdata0 | rdata1, W'(0));
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_mid_reset", W'({rdy0, rdy1}), W'(3));
        @(posedge clk);
        #1;
        read_line(28'h40);

        repeat (4) @(posedge clk);
        #1;
        check_eq("scoreboard_drained", W'(q0.size() + q1.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
